rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for an N:1 bit multiplexer datapath.
- Shares the mux output among N requesters: chooses one owner, drives the select, holds it for the owner's transfer, then rotates fairly.
- Sits directly in front of the generic N:1 mux. Its sel output connects to the mux select port. It also contains an equivalent internal mux, so it can be used standalone.

---
 rtl/rr_mux_arbiter.sv | 109 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of an N:1 bit mux, holding each owner
// for at most MAX_HOLD cycles before rotating to the next requester.
module rr_mux_arbiter #(
  parameter int n        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [n-1:0]         req,
  input  logic                 done,
  input  logic [n-1:0]         I,
  output logic [n-1:0]         grant,
  output logic [$clog2(n)-1:0] sel,
  output logic                 valid,
  output logic                 out
);

  localparam int SW = $clog2(n);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Handshake: req is a level; while valid is high the requester at sel owns the
  // mux and keeps req high until it pulses done (or simply drops req) to let go.
  logic [0:0]    state, nxt_state;
  logic [SW-1:0] ptr, nxt_ptr;
  logic [SW-1:0] nxt_sel;
  logic          nxt_valid;
  logic [HW-1:0] hold_cnt, nxt_hold;
  logic [n-1:0]  one;
  logic [n-1:0]  masked_req;
  logic          release_now;
  logic [SW:0]   pick_idle, pick_rel;

  // Returns {found, index} of the first set bit of r at or after p, wrapping.
  function automatic logic [SW:0] pick(input logic [n-1:0] r, input logic [SW-1:0] p);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    for (int i = n - 1; i >= 0; i--) begin
      idx = p + SW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign one         = {{(n-1){1'b0}}, 1'b1};
  assign masked_req  = req & ~(one << sel);
  assign release_now = done | ~req[sel] | (hold_cnt == HW'(MAX_HOLD - 1));
  assign pick_idle   = pick(req, ptr);
  assign pick_rel    = pick(masked_req, sel + SW'(1));

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_sel   = sel;
    nxt_valid = valid;
    nxt_hold  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_idle[SW]) begin
          nxt_state = BUSY;
          nxt_sel   = pick_idle[SW-1:0];
          nxt_valid = 1'b1;
          nxt_hold  = '0;
        end
      end
      default: begin
        if (release_now) begin
          nxt_ptr  = sel + SW'(1);
          nxt_hold = '0;
          if (pick_rel[SW]) begin
            nxt_sel = pick_rel[SW-1:0];
          end else if (req[sel]) begin
            // Sole remaining requester: hand the mux straight back to it.
            nxt_sel = sel;
          end else begin
            nxt_state = IDLE;
            nxt_valid = 1'b0;
          end
        end else begin
          nxt_hold = hold_cnt + HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      grant    <= '0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      sel      <= nxt_sel;
      valid    <= nxt_valid;
      hold_cnt <= nxt_hold;
      grant    <= nxt_valid ? (one << nxt_sel) : '0;
    end
  end

  assign out = valid & I[sel];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, self-regrant, rotation, timeout
// fairness, request drop with wrap, and skip-ahead arbitration.
module tb_rr_mux_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] I;
  logic [N-1:0] grant;
  logic [2:0]   sel;
  logic         valid;
  logic         out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [N-1:0] i_pat;

  rr_mux_arbiter #(.n(N), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .I(I),
    .grant(grant), .sel(sel), .valid(valid), .out(out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // owner checks against a bench-computed select value
  task automatic check_owner(input string tag, input logic [2:0] exp_sel);
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_sel"}, {29'd0, sel}, {29'd0, exp_sel});
    check({tag, "_grant"}, {24'd0, grant}, 32'd1 << exp_sel);
    check({tag, "_out"}, {31'd0, out}, {31'd0, i_pat[exp_sel]});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_grant"}, {24'd0, grant}, 32'd0);
    check({tag, "_out"}, {31'd0, out}, 32'd0);
  endtask

  initial begin
    i_pat = 8'b1010_1010;
    I     = i_pat;
    do_reset();
    tick();
    check_idle("reset");
    check("reset_sel", {29'd0, sel}, 32'd0);

    // single requester: grant after one edge, regrant to itself every 4 cycles
    req = 8'b0000_0100;
    tick();
    check_owner("single_first", 3'd2);
    check("single_hold0", {30'd0, dut.hold_cnt}, 32'd0);
    for (int k = 1; k < 9; k++) begin
      tick();
      check_owner("single_keep", 3'd2);
      check("single_hold", {30'd0, dut.hold_cnt}, k % 4);
    end

    // asynchronous reset mid-grant clears outputs without a clock edge
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // full request with done every cycle: 0..7,0 with no bubbles
    for (int k = 0; k < 9; k++) exp_q.push_back(8'(k % 8));
    req  = 8'hFF;
    done = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_owner("rotate", e[2:0]);
    end
    req  = '0;
    done = 1'b0;
    tick();
    check_idle("rotate_end");

    // timeout fairness between two requesters, from pointer 0
    do_reset();
    for (int k = 0; k < 16; k++) exp_q.push_back(((k / 4) % 2 == 0) ? 8'd0 : 8'd1);
    req = 8'b0000_0011;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_owner("timeout", e[2:0]);
    end
    req = '0;
    tick();
    check_idle("timeout_end");

    // request drop with pointer wrap 7 -> 0, then idle keeps sel
    req = 8'b1000_0000;
    tick();
    check_owner("wrap_owner7", 3'd7);
    req = 8'b0000_0001;
    tick();
    check_owner("wrap_to0", 3'd0);
    req = '0;
    tick();
    check_idle("wrap_drop");
    check("wrap_sel_kept", {29'd0, sel}, 32'd0);

    // done while idle has no effect
    done = 1'b1;
    tick();
    check_idle("idle_done");
    done = 1'b0;

    // skip-ahead: owner 2 drops, pointer 3, 6 wins over 1; then 1 after release
    req = 8'b0000_0100;
    tick();
    check_owner("skip_owner2", 3'd2);
    req = 8'b0100_0010;
    tick();
    check_owner("skip_to6", 3'd6);
    done = 1'b1;
    tick();
    check_owner("skip_to1", 3'd1);
    done = 1'b0;
    req  = '0;
    tick();
    check_idle("skip_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
